sample_sequencer: RTL and testbench
===================================

SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 Parameter SAMPLE_W, default 16, width of sample datapath.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 n_reset  input  1  reset n_reset, asynchronous, active-low.
REQ-004 data_ready  input  1  producer strobe; level high = new sample on sample_in, asynchronous to clk.
REQ-005 sample_in  input  SAMPLE_W  producer sample data, stable while data_ready high.
REQ-006 one_k_samples  input  1  from sample counter; high when count >= 1000.
REQ-007 cnt_up  output  1  one-cycle pulse per accepted sample, drives sample counter.
REQ-008 clear  output  1  one-cycle pulse restarting the sample counter after a 1000-sample block.
REQ-009 modwait  output  1  busy; high from sample capture until the sequencer returns to IDLE.
REQ-010 sample_out  output  SAMPLE_W  last accepted sample, registered.
REQ-011 sample_valid  output  1  one-cycle pulse, coincident with cnt_up, marking sample_out update.
REQ-012 block_done  output  1  one-cycle pulse when the 1000th sample has been accepted.
REQ-013 err  output  1  level; protocol error flag.

Function
REQ-014 data_ready SHALL pass through a 2-flop synchronizer; only its synchronized rising edge (rise) starts a transaction.
REQ-015 FSM states SHALL be IDLE, LOAD, COUNT, CHECK, DONE, ERR.
REQ-016 IDLE: modwait=0; rise -> LOAD; otherwise stay.
REQ-017 LOAD: sample_out <= sample_in; modwait=1; synchronized data_ready still high -> COUNT, low -> ERR.
REQ-018 COUNT: cnt_up=1, sample_valid=1 for exactly this cycle; modwait=1; -> CHECK unconditionally.
REQ-019 CHECK: one_k_samples sampled here, one cycle after cnt_up; high -> DONE, low -> IDLE; modwait=1.
REQ-020 DONE: block_done=1, clear=1 for exactly one cycle; modwait=1; -> IDLE.
REQ-021 ERR: err=1, modwait=0, no cnt_up; rise -> LOAD with err cleared on that transition.
REQ-022 Rises arriving while in LOAD, COUNT, CHECK or DONE SHALL be dropped, not queued; err unaffected.
REQ-023 Latency rise-detect -> cnt_up SHALL be exactly 2 clk cycles (IDLE->LOAD->COUNT).
REQ-024 Minimum accepted sample spacing SHALL be 4 clk cycles (LOAD, COUNT, CHECK, IDLE); 5 when DONE is inserted.
REQ-025 cnt_up and clear SHALL never be high in the same cycle.
REQ-026 Outputs SHALL be registered or pure decodes of the state register only; no combinational path from inputs to outputs.
REQ-027 one_k_samples high in CHECK with fewer than 1000 internal accepts is not checked; sequencer trusts counter.

Reset
REQ-028 n_reset low SHALL force state IDLE, synchronizer flops 0, sample_out 0, all strobes 0, modwait 0, err 0, immediately and independent of clk.
REQ-029 Reset asserted mid-transaction SHALL abandon the sample; no cnt_up, sample_valid or block_done pulse after release.
REQ-030 After n_reset release, a data_ready already high SHALL NOT count as a rise until it goes low and high again.

Structure
REQ-031 Shared package seq_pkg SHALL hold the state enum typedef and the SAMPLE_W default constant.
REQ-032 Synchronizer plus rising-edge detect SHALL be one sub-module, sync_rise (inputs clk, n_reset, async_in; output rise).
REQ-033 Datapath register and FSM SHALL reside in sample_sequencer; counter stays external.

Verification
REQ-034 Reset, then data_ready pulse 3 cycles with sample_in=16'hA5A5 -> cnt_up and sample_valid one pulse 2 cycles after rise detect, sample_out=16'hA5A5, modwait high 3 cycles.
REQ-035 data_ready high 1 cycle only (drops before LOAD check) -> err=1, no cnt_up; next full pulse -> err=0, one cnt_up.
REQ-036 1000 spaced pulses with model counter -> exactly 1000 cnt_up, one block_done and one clear on 1000th, counter back to 0.
REQ-037 Second rise 1 cycle after first -> only one cnt_up; err stays 0.
REQ-038 n_reset asserted during COUNT-bound LOAD -> all outputs 0 asynchronously, no cnt_up after release with data_ready held high.
REQ-039 Assertions on every test: cnt_up and clear never coincident; cnt_up == sample_valid every cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the sample sequencer.
// Holds the FSM state encoding and the default sample width.
package seq_pkg;

    localparam int SAMPLE_W_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_COUNT = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer with rising-edge detect for an async strobe.
// Ports: clk, n_reset, async_in -> rise (1-cycle pulse), level (synced).
module sync_rise (
    input  logic clk,
    input  logic n_reset,
    input  logic async_in,
    output logic rise,
    output logic level
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q, prev_d;
    logic       armed_q, armed_d;
    logic [1:0] fill_q, fill_d;

    // fill_q[1] marks that sync2_q holds a post-reset sample.
    // Edges are only honoured once the input has been seen low
    // after reset, so a strobe held across reset is ignored.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & ~sync2_q);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            fill_q  <= fill_d;
        end
    end

    assign rise  = armed_q & sync2_q & ~prev_q;
    assign level = sync2_q;

endmodule

// File: rtl/sample_sequencer.sv
// Sample capture sequencer: syncs producer strobe, latches samples,
// pulses cnt_up/sample_valid per sample and block_done/clear per 1000.
// Ports: clk, n_reset, data_ready, sample_in, one_k_samples ->
//        cnt_up, clear, modwait, sample_out, sample_valid, block_done, err.
module sample_sequencer
    import seq_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                data_ready,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                one_k_samples,
    output logic                cnt_up,
    output logic                clear,
    output logic                modwait,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                block_done,
    output logic                err
);

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                rise;
    logic                ready_sync;

    sync_rise u_sync (
        .clk      (clk),
        .n_reset  (n_reset),
        .async_in (data_ready),
        .rise     (rise),
        .level    (ready_sync)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= S_IDLE;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
        end
    end

    // Rises outside IDLE/ERR are dropped by simply not looking at them.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rise) state_d = S_LOAD;
            S_LOAD:  state_d = ready_sync ? S_COUNT : S_ERR;
            S_COUNT: state_d = S_CHECK;
            S_CHECK: state_d = one_k_samples ? S_DONE : S_IDLE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   if (rise) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sample_d = sample_q;
        if (state_q == S_LOAD) sample_d = sample_in;
    end

    always_comb begin
        cnt_up       = 1'b0;
        sample_valid = 1'b0;
        clear        = 1'b0;
        block_done   = 1'b0;
        modwait      = 1'b0;
        err          = 1'b0;
        case (state_q)
            S_LOAD:  modwait = 1'b1;
            S_COUNT: begin
                modwait      = 1'b1;
                cnt_up       = 1'b1;
                sample_valid = 1'b1;
            end
            S_CHECK: modwait = 1'b1;
            S_DONE:  begin
                modwait    = 1'b1;
                block_done = 1'b1;
                clear      = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

    assign sample_out = sample_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer with an external counter model.
// Checks timing histories per scenario plus per-cycle strobe invariants.
module tb_sample_sequencer;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        data_ready = 1'b0;
    logic [15:0] sample_in = 16'h0;
    logic        one_k_samples;
    logic        cnt_up, clear, modwait, sample_valid, block_done, err;
    logic [15:0] sample_out;

    int vectors = 0;
    int miscompares = 0;
    int count_q = 0;

    always #5 clk = ~clk;

    sample_sequencer #(.SAMPLE_W(16)) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .data_ready    (data_ready),
        .sample_in     (sample_in),
        .one_k_samples (one_k_samples),
        .cnt_up        (cnt_up),
        .clear         (clear),
        .modwait       (modwait),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .block_done    (block_done),
        .err           (err)
    );

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) count_q <= 0;
        else if (clear) count_q <= 0;
        else if (cnt_up) count_q <= count_q + 1;
    end
    assign one_k_samples = (count_q >= 1000);

    always @(negedge clk) begin
        vectors = vectors + 1;
        if (cnt_up !== sample_valid) begin
            miscompares = miscompares + 1;
            $display("FAIL strobe_eq cnt_up=%b sample_valid=%b t=%0t",
                     cnt_up, sample_valid, $time);
        end
        if (cnt_up === 1'b1 && clear === 1'b1) begin
            miscompares = miscompares + 1;
            $display("FAIL cnt_clear_overlap both high t=%0t", $time);
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset    = 1'b0;
        data_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Raise data_ready at the current negedge (N0), hold n_high
    // negedges, then record outputs at N1..N10.
    task automatic pulse(input int n_high, input logic [15:0] d,
                         output logic [10:0] cnt_h,
                         output logic [10:0] mw_h,
                         output logic [10:0] err_h,
                         output logic [10:0] bd_h);
        cnt_h = '0; mw_h = '0; err_h = '0; bd_h = '0;
        sample_in  = d;
        data_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            cnt_h[i] = cnt_up;
            mw_h[i]  = modwait;
            err_h[i] = err;
            bd_h[i]  = block_done;
            if (i == n_high) data_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        chk("rst_cnt_up", 32'(cnt_up), 32'd0);
        chk("rst_modwait", 32'(modwait), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_sample_out", 32'(sample_out), 32'd0);
        chk("rst_block_done", 32'(block_done), 32'd0);
        chk("rst_clear", 32'(clear), 32'd0);
        do_reset();
        chk("idle_modwait", 32'(modwait), 32'd0);
    endtask

    task automatic test_basic();
        logic [10:0] c, m, e, b;
        pulse(3, 16'hA5A5, c, m, e, b);
        chk("basic_cnt_hist", 32'(c), 32'(11'b00000010000));
        chk("basic_mw_hist", 32'(m), 32'(11'b00000111000));
        chk("basic_err_hist", 32'(e), 32'd0);
        chk("basic_bd_hist", 32'(b), 32'd0);
        chk("basic_sample_out", 32'(sample_out), 32'h0000A5A5);
        chk("basic_count", 32'(count_q), 32'd1);
    endtask

    task automatic test_err();
        logic [10:0] c, m, e, b;
        pulse(1, 16'h1234, c, m, e, b);
        chk("err_cnt_hist", 32'(c), 32'd0);
        chk("err_mw_hist", 32'(m), 32'(11'b00000001000));
        chk("err_err_hist", 32'(e), 32'(11'b11111110000));
        pulse(3, 16'h5A5A, c, m, e, b);
        chk("rec_cnt_hist", 32'(c), 32'(11'b00000010000));
        chk("rec_err_hist", 32'(e), 32'(11'b00000000110));
        chk("rec_mw_hist", 32'(m), 32'(11'b00000111000));
        chk("rec_sample_out", 32'(sample_out), 32'h00005A5A);
    endtask

    task automatic test_back_to_back();
        int ncnt = 0;
        int nerr = 0;
        sample_in  = 16'hBEEF;
        data_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            ncnt += int'(cnt_up);
            nerr += int'(err);
            if (i == 2) data_ready = 1'b0;
            if (i == 3) data_ready = 1'b1;
            if (i == 6) data_ready = 1'b0;
        end
        chk("b2b_cnt_pulses", 32'(ncnt), 32'd1);
        chk("b2b_err_cycles", 32'(nerr), 32'd0);
        chk("b2b_modwait_end", 32'(modwait), 32'd0);
    endtask

    task automatic test_reset_mid();
        int ncnt = 0;
        int nmw = 0;
        logic [10:0] c, m, e, b;
        sample_in  = 16'hC3C3;
        data_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_in_load", 32'(modwait), 32'd1);
        #2 n_reset = 1'b0;
        #1;
        chk("mid_modwait", 32'(modwait), 32'd0);
        chk("mid_cnt_up", 32'(cnt_up), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        chk("mid_sample_out", 32'(sample_out), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ncnt += int'(cnt_up);
            nmw  += int'(modwait);
        end
        chk("held_cnt_pulses", 32'(ncnt), 32'd0);
        chk("held_modwait", 32'(nmw), 32'd0);
        chk("held_sample_out", 32'(sample_out), 32'd0);
        data_ready = 1'b0;
        repeat (4) @(negedge clk);
        pulse(3, 16'h0F0F, c, m, e, b);
        chk("post_cnt_hist", 32'(c), 32'(11'b00000010000));
    endtask

    task automatic test_block();
        logic [10:0] c, m, e, b;
        int ncnt = 0;
        int nbd = 0;
        int nclr = 0;
        int bd_at = -1;
        do_reset();
        for (int s = 0; s < 1000; s++) begin
            pulse(3, 16'(s), c, m, e, b);
            ncnt += $countones(c);
            nbd  += $countones(b);
            if (b != 0 && bd_at < 0) bd_at = s;
            if (s == 998) chk("blk_count_998", 32'(count_q), 32'd999);
        end
        nclr = nbd;
        chk("blk_cnt_pulses", 32'(ncnt), 32'd1000);
        chk("blk_done_pulses", 32'(nbd), 32'd1);
        chk("blk_done_at", 32'(bd_at), 32'd999);
        chk("blk_done_slot", 32'(b), 32'(11'b00001000000));
        chk("blk_counter", 32'(count_q), 32'd0);
        chk("blk_sample_out", 32'(sample_out), 32'd999);
        if (nclr != 0) ;
    endtask

    int nclr_total = 0;
    always @(negedge clk) if (clear === 1'b1) nclr_total++;

    initial begin
        test_reset();
        test_basic();
        test_err();
        test_back_to_back();
        test_reset_mid();
        nclr_total = 0;
        test_block();
        chk("blk_clear_pulses", 32'(nclr_total), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
